ten_bit_reg_arbiter: RTL and testbench

Round-robin write arbiter that shares one 10-bit load-enabled register (the `tenBitReg` datapath) among `NUM_REQ` requesters. Each requester raises a request with its data. The arbiter grants one requester at a time, captures that requester's data, and issues a single load pulse to the register. It then acknowledges the winner. It sits between the requesting blocks and the register's data/load inputs, and is the only driver of those inputs.

---
 rtl/ten_bit_reg_arbiter.sv | 105 ++++++++++
 tb/tb_ten_bit_reg_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ten_bit_reg_arbiter.sv
// ten_bit_reg_arbiter: round-robin arbiter sharing one load-enabled register among NUM_REQ writers
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   req, wr_data   : per-requester level request and data slice [i*WIDTH +: WIDTH]
//   grant, ack     : one-hot owner, one-cycle acknowledge at load
//   reg_d, reg_ld  : register data and one-cycle load strobe
//   busy           : high while in GRANT or LOAD
//   REG_ARB_FIXED_PRIO_EN : when defined, lowest-index request always wins
module ten_bit_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         reg_d,
  output logic                     reg_ld,
  output logic                     busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, LOAD} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, win, win_n, nxt_ptr, start, pick, sel;
  logic [PW:0] idx;
  logic [NUM_REQ-1:0] arb_req, grant_n, ack_n;
  logic [WIDTH-1:0] reg_d_n;
  logic reg_ld_n, busy_n, found;
  assign nxt_ptr = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  // In LOAD the current winner (grant) is masked so it cannot win twice in a row.
  always_comb begin
    arb_req = (state == LOAD) ? req & ~grant : req;
`ifdef REG_ARB_FIXED_PRIO_EN
    start = '0;
`else
    start = (state == LOAD) ? nxt_ptr : ptr;
`endif
    pick = '0;
    found = 1'b0;
    idx = '0;
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, start} + (PW+1)'(i);
      idx = (idx >= (PW+1)'(NUM_REQ)) ? idx - (PW+1)'(NUM_REQ) : idx;
      sel = idx[PW-1:0];
      if (!found && arb_req[sel]) begin
        pick = sel;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    win_n = win;
    grant_n = grant;
    ack_n = '0;
    reg_ld_n = 1'b0;
    reg_d_n = reg_d;
    unique case (state)
      IDLE: begin
        state_n = found ? GRANT : IDLE;
        win_n = found ? pick : win;
        grant_n = found ? NUM_REQ'(1) << pick : '0;
      end
      GRANT: begin
        state_n = req[win] ? LOAD : IDLE;
        reg_d_n = req[win] ? wr_data[win*WIDTH +: WIDTH] : reg_d;
        reg_ld_n = req[win];
        ack_n = req[win] ? grant : '0;
        grant_n = req[win] ? grant : '0;
      end
      LOAD: begin
        ptr_n = nxt_ptr;
        state_n = found ? GRANT : IDLE;
        win_n = found ? pick : win;
        grant_n = found ? NUM_REQ'(1) << pick : '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      grant <= '0;
      ack <= '0;
      reg_ld <= 1'b0;
      reg_d <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      win <= win_n;
      grant <= grant_n;
      ack <= ack_n;
      reg_ld <= reg_ld_n;
      reg_d <= reg_d_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_ten_bit_reg_arbiter.sv
// tb_ten_bit_reg_arbiter: directed self-checking bench for ten_bit_reg_arbiter
module tb_ten_bit_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [39:0] wr_data = '0;
  logic [3:0] grant, ack;
  logic [9:0] reg_d;
  logic reg_ld, busy;
  int total = 0;
  int bad = 0;
  logic [9:0] rr_d [4] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
  always #5 clk = ~clk;
  ten_bit_reg_arbiter #(.NUM_REQ(4), .WIDTH(10)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_data(wr_data),
    .grant(grant), .ack(ack), .reg_d(reg_d), .reg_ld(reg_ld), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    chk("ld_eq_ack", {31'd0, reg_ld}, {31'd0, |ack});
    chk("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
  endtask
  initial begin
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick;
      chk("rst_grant", grant, 0);
      chk("rst_ack", ack, 0);
      chk("rst_ld", reg_ld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_d", reg_d, 0);
    end
    rst = 1'b0;
    tick;
    chk("rel_grant", grant, 4'b0001);
    req = '0;
    tick;
    chk("rel_abort_grant", grant, 0);
    chk("rel_abort_ld", reg_ld, 0);
    wr_data[29:20] = 10'b0101010101;
    req = 4'b0100;
    tick;
    chk("sw_grant", grant, 4'b0100);
    chk("sw_busy", busy, 1);
    chk("sw_ld0", reg_ld, 0);
    tick;
    chk("sw_d", reg_d, 10'b0101010101);
    chk("sw_ld", reg_ld, 1);
    chk("sw_ack", ack, 4'b0100);
    req = '0;
    tick;
    chk("sw_idle_grant", grant, 0);
    chk("sw_idle_ld", reg_ld, 0);
    chk("sw_idle_busy", busy, 0);
    req = 4'b0010;
    tick;
    chk("ab_grant", grant, 4'b0010);
    req = '0;
    tick;
    chk("ab_grant_clr", grant, 0);
    chk("ab_ld", reg_ld, 0);
    chk("ab_ack", ack, 0);
    chk("ab_d", reg_d, 10'b0101010101);
    chk("ab_busy", busy, 0);
    req = 4'b1010;
    tick;
`ifdef REG_ARB_FIXED_PRIO_EN
    chk("ptr_keep", grant, 4'b0010);
`else
    chk("ptr_keep", grant, 4'b1000);
`endif
    req = '0;
    tick;
    chk("ptr_abort", grant, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk("rst2_d", reg_d, 0);
    wr_data = {10'h2AA, 10'h155, 10'h000, 10'h3FF};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_grant", grant, 32'd1 << k);
      chk("rr_ld0", reg_ld, 0);
      tick;
      chk("rr_ld", reg_ld, 1);
      chk("rr_ack", ack, 32'd1 << k);
      chk("rr_d", reg_d, rr_d[k]);
      req[k] = 1'b0;
    end
    tick;
    chk("rr_end_grant", grant, 0);
    chk("rr_end_busy", busy, 0);
    wr_data[9:0] = 10'b1111100000;
    req = 4'b0001;
    tick;
    chk("mr_grant", grant, 4'b0001);
    rst = 1'b1;
    tick;
    chk("mr_ld", reg_ld, 0);
    chk("mr_ack", ack, 0);
    chk("mr_d", reg_d, 0);
    chk("mr_grant_clr", grant, 0);
    rst = 1'b0;
    req = '0;
    tick;
    chk("mr_ld_after", reg_ld, 0);
    chk("mr_d_after", reg_d, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
